// File: rtl/chan_reconfig_sequencer.sv
// Run-time reconfiguration sequencer for the M/2 channelizer chain.
// Requests are validated, then the datapath is drained, held in reset and its FFT core reconfigured.
module chan_reconfig_sequencer #(
    parameter int FFT_SIZE_WIDTH = 12,
    parameter int PAYLOAD_WIDTH  = 16,
    parameter int RESET_CYCLES   = 8,
    parameter int DRAIN_TIMEOUT  = 4096,
    parameter int DEF_FFT_SIZE   = 8,
    parameter int DEF_PAYLOAD    = 16
) (
    input  logic                      clk,
    input  logic                      sync_reset,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [FFT_SIZE_WIDTH-1:0] cfg_fft_size,
    input  logic [PAYLOAD_WIDTH-1:0]  cfg_payload_length,
    output logic                      cfg_err,
    input  logic                      out_tvalid,
    input  logic                      out_tready,
    input  logic                      out_tlast,
    output logic                      gate_input,
    output logic                      datapath_reset,
    output logic                      fft_aresetn,
    output logic                      fft_config_tvalid,
    output logic [15:0]               fft_config_tdata,
    input  logic                      fft_config_tready,
    output logic [FFT_SIZE_WIDTH-1:0] fft_size,
    output logic [PAYLOAD_WIDTH-1:0]  payload_length_m1,
    output logic                      busy
);

    localparam int RST_CNT_W  = $clog2(RESET_CYCLES);
    localparam int IDLE_CNT_W = (DRAIN_TIMEOUT > 2) ? $clog2(DRAIN_TIMEOUT) : 1;

    localparam logic [RST_CNT_W-1:0]      RST_CNT_INIT = RST_CNT_W'(RESET_CYCLES - 1);
    localparam logic [IDLE_CNT_W-1:0]     IDLE_LIMIT   = IDLE_CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [4:0]                DEF_NFFT     = 5'($clog2(DEF_FFT_SIZE));
    localparam logic [FFT_SIZE_WIDTH-1:0] DEF_SIZE     = FFT_SIZE_WIDTH'(DEF_FFT_SIZE);
    localparam logic [PAYLOAD_WIDTH-1:0]  DEF_PAY_M1   = PAYLOAD_WIDTH'(DEF_PAYLOAD - 1);

    typedef enum logic [1:0] {S_RST, S_CFG, S_RUN, S_DRAIN} state_t;

    state_t                    state_q, state_d;
    logic [RST_CNT_W-1:0]      rst_cnt_q, rst_cnt_d;
    logic [IDLE_CNT_W-1:0]     idle_cnt_q, idle_cnt_d;
    logic [FFT_SIZE_WIDTH-1:0] pend_fft_size_q, pend_fft_size_d;
    logic [PAYLOAD_WIDTH-1:0]  pend_payload_m1_q, pend_payload_m1_d;
    logic [4:0]                pend_nfft_q, pend_nfft_d;
    logic [FFT_SIZE_WIDTH-1:0] fft_size_q, fft_size_d;
    logic [PAYLOAD_WIDTH-1:0]  payload_length_m1_q, payload_length_m1_d;
    logic [4:0]                nfft_q, nfft_d;
    logic                      cfg_err_q, cfg_err_d;
    logic                      cfg_ready_q, cfg_ready_d;
    logic                      gate_input_q, gate_input_d;
    logic                      datapath_reset_q, datapath_reset_d;
    logic                      fft_aresetn_q, fft_aresetn_d;
    logic                      fft_config_tvalid_q, fft_config_tvalid_d;
    logic [15:0]               fft_config_tdata_q, fft_config_tdata_d;
    logic                      busy_q, busy_d;

    logic       cfg_hs, out_xfer, out_last;
    logic [4:0] req_log2;
    logic       req_pow2, req_valid;

    function automatic logic [4:0] size_log2(input logic [FFT_SIZE_WIDTH-1:0] size);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < FFT_SIZE_WIDTH; i++) begin
            if (size[i]) r = 5'(i);
        end
        return r;
    endfunction

    // A request is legal only for a power-of-two FFT size in 8..2048 and a non-zero payload.
    always_comb begin
        cfg_hs    = cfg_valid & cfg_ready_q;
        out_xfer  = out_tvalid & out_tready;
        out_last  = out_xfer & out_tlast;
        req_log2  = size_log2(cfg_fft_size);
        req_pow2  = (cfg_fft_size != '0) &&
                    ((cfg_fft_size & (cfg_fft_size - FFT_SIZE_WIDTH'(1))) == '0);
        req_valid = req_pow2 && (req_log2 >= 5'd3) && (req_log2 <= 5'd11) &&
                    (cfg_payload_length != '0);
    end

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) state_q <= S_RST;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d             = state_q;
        rst_cnt_d           = rst_cnt_q;
        idle_cnt_d          = idle_cnt_q;
        pend_fft_size_d     = pend_fft_size_q;
        pend_payload_m1_d   = pend_payload_m1_q;
        pend_nfft_d         = pend_nfft_q;
        fft_size_d          = fft_size_q;
        payload_length_m1_d = payload_length_m1_q;
        nfft_d              = nfft_q;
        cfg_err_d           = 1'b0;
        case (state_q)
            S_RST: begin
                if (rst_cnt_q == '0) state_d = S_CFG;
                else                 rst_cnt_d = rst_cnt_q - RST_CNT_W'(1);
            end
            S_CFG: begin
                if (fft_config_tvalid_q && fft_config_tready) state_d = S_RUN;
            end
            S_RUN: begin
                if (cfg_hs) begin
                    if (req_valid) begin
                        pend_fft_size_d   = cfg_fft_size;
                        pend_payload_m1_d = cfg_payload_length - PAYLOAD_WIDTH'(1);
                        pend_nfft_d       = req_log2;
                        idle_cnt_d        = '0;
                        state_d           = S_DRAIN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                // Leave on a frame boundary, or give up once the output has been idle too long.
                if (out_last || (!out_xfer && idle_cnt_q == IDLE_LIMIT)) begin
                    state_d             = S_RST;
                    rst_cnt_d           = RST_CNT_INIT;
                    fft_size_d          = pend_fft_size_q;
                    payload_length_m1_d = pend_payload_m1_q;
                    nfft_d              = pend_nfft_q;
                end else if (out_xfer) begin
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_CNT_W'(1);
                end
            end
            default: state_d = S_RST;
        endcase
    end

    // Outputs are decoded from the upcoming state so every port comes straight from a flop.
    always_comb begin
        datapath_reset_d    = (state_d == S_RST);
        fft_aresetn_d       = (state_d != S_RST);
        gate_input_d        = (state_d != S_RUN);
        busy_d              = (state_d != S_RUN);
        cfg_ready_d         = (state_d == S_RUN);
        fft_config_tvalid_d = (state_d == S_CFG);
        fft_config_tdata_d  = {11'd0, nfft_d};
    end

    always_ff @(posedge clk or posedge sync_reset) begin
        if (sync_reset) begin
            rst_cnt_q           <= RST_CNT_INIT;
            idle_cnt_q          <= '0;
            pend_fft_size_q     <= DEF_SIZE;
            pend_payload_m1_q   <= DEF_PAY_M1;
            pend_nfft_q         <= DEF_NFFT;
            fft_size_q          <= DEF_SIZE;
            payload_length_m1_q <= DEF_PAY_M1;
            nfft_q              <= DEF_NFFT;
            cfg_err_q           <= 1'b0;
            cfg_ready_q         <= 1'b0;
            gate_input_q        <= 1'b1;
            datapath_reset_q    <= 1'b1;
            fft_aresetn_q       <= 1'b0;
            fft_config_tvalid_q <= 1'b0;
            fft_config_tdata_q  <= {11'd0, DEF_NFFT};
            busy_q              <= 1'b1;
        end else begin
            rst_cnt_q           <= rst_cnt_d;
            idle_cnt_q          <= idle_cnt_d;
            pend_fft_size_q     <= pend_fft_size_d;
            pend_payload_m1_q   <= pend_payload_m1_d;
            pend_nfft_q         <= pend_nfft_d;
            fft_size_q          <= fft_size_d;
            payload_length_m1_q <= payload_length_m1_d;
            nfft_q              <= nfft_d;
            cfg_err_q           <= cfg_err_d;
            cfg_ready_q         <= cfg_ready_d;
            gate_input_q        <= gate_input_d;
            datapath_reset_q    <= datapath_reset_d;
            fft_aresetn_q       <= fft_aresetn_d;
            fft_config_tvalid_q <= fft_config_tvalid_d;
            fft_config_tdata_q  <= fft_config_tdata_d;
            busy_q              <= busy_d;
        end
    end

    assign cfg_ready         = cfg_ready_q;
    assign cfg_err           = cfg_err_q;
    assign gate_input        = gate_input_q;
    assign datapath_reset    = datapath_reset_q;
    assign fft_aresetn       = fft_aresetn_q;
    assign fft_config_tvalid = fft_config_tvalid_q;
    assign fft_config_tdata  = fft_config_tdata_q;
    assign fft_size          = fft_size_q;
    assign payload_length_m1 = payload_length_m1_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_chan_reconfig_sequencer.sv
// Randomized self-checking bench for chan_reconfig_sequencer.
// The reference model tracks the active configuration and predicts cycle counts from the request rules.
module tb_chan_reconfig_sequencer;

    localparam int RESET_CYCLES  = 8;
    localparam int DRAIN_TIMEOUT = 4096;

    logic        clk;
    logic        sync_reset;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [11:0] cfg_fft_size;
    logic [15:0] cfg_payload_length;
    logic        cfg_err;
    logic        out_tvalid;
    logic        out_tready;
    logic        out_tlast;
    logic        gate_input;
    logic        datapath_reset;
    logic        fft_aresetn;
    logic        fft_config_tvalid;
    logic [15:0] fft_config_tdata;
    logic        fft_config_tready;
    logic [11:0] fft_size;
    logic [15:0] payload_length_m1;
    logic        busy;

    int checks = 0;
    int errors = 0;

    int model_fft_size;
    int model_pay_m1;

    chan_reconfig_sequencer #(
        .FFT_SIZE_WIDTH(12),
        .PAYLOAD_WIDTH (16),
        .RESET_CYCLES  (RESET_CYCLES),
        .DRAIN_TIMEOUT (DRAIN_TIMEOUT),
        .DEF_FFT_SIZE  (8),
        .DEF_PAYLOAD   (16)
    ) dut (
        .clk               (clk),
        .sync_reset        (sync_reset),
        .cfg_valid         (cfg_valid),
        .cfg_ready         (cfg_ready),
        .cfg_fft_size      (cfg_fft_size),
        .cfg_payload_length(cfg_payload_length),
        .cfg_err           (cfg_err),
        .out_tvalid        (out_tvalid),
        .out_tready        (out_tready),
        .out_tlast         (out_tlast),
        .gate_input        (gate_input),
        .datapath_reset    (datapath_reset),
        .fft_aresetn       (fft_aresetn),
        .fft_config_tvalid (fft_config_tvalid),
        .fft_config_tdata  (fft_config_tdata),
        .fft_config_tready (fft_config_tready),
        .fft_size          (fft_size),
        .payload_length_m1 (payload_length_m1),
        .busy              (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic bit model_valid(int size, int pay);
        bit size_ok;
        size_ok = 1'b0;
        for (int k = 3; k <= 11; k++) begin
            if (size == (1 << k)) size_ok = 1'b1;
        end
        return size_ok && (pay != 0);
    endfunction

    function automatic int model_log2(int size);
        int n;
        n = 0;
        while ((1 << n) < size) n++;
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_defaults();
        model_fft_size = 8;
        model_pay_m1   = 15;
    endtask

    // Observes a reset pulse already visible on datapath_reset, then the config handshake.
    task automatic expect_reset_and_config(input string tag, input int stall);
        int          n;
        bit          hold_ok;
        bit          rst_ok;
        logic [15:0] word;
        word = 16'(model_log2(model_fft_size));
        checks++;
        if (datapath_reset !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s reset_start datapath_reset got %b want 1", tag, datapath_reset);
        end
        n = 0;
        rst_ok = 1'b1;
        while (datapath_reset === 1'b1 && n < 100) begin
            n++;
            if (fft_aresetn !== 1'b0 || gate_input !== 1'b1 || busy !== 1'b1 ||
                cfg_ready !== 1'b0 || fft_config_tvalid !== 1'b0 || cfg_err !== 1'b0)
                rst_ok = 1'b0;
            step();
        end
        checks++;
        if (!rst_ok) begin
            errors++;
            $display("[TB] FAIL %s reset_outputs got aresetn=%b gate=%b busy=%b ready=%b tvalid=%b want 0/1/1/0/0",
                     tag, fft_aresetn, gate_input, busy, cfg_ready, fft_config_tvalid);
        end
        checks++;
        if (n !== RESET_CYCLES) begin
            errors++;
            $display("[TB] FAIL %s reset_width got %0d want %0d", tag, n, RESET_CYCLES);
        end
        checks++;
        if (fft_config_tvalid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s cfg_tvalid_rise got %b want 1", tag, fft_config_tvalid);
        end
        checks++;
        if (fft_config_tdata !== word) begin
            errors++;
            $display("[TB] FAIL %s cfg_tdata got 0x%04h want 0x%04h", tag, fft_config_tdata, word);
        end
        checks++;
        if (fft_size !== 12'(model_fft_size) || payload_length_m1 !== 16'(model_pay_m1)) begin
            errors++;
            $display("[TB] FAIL %s active_cfg got %0d/%0d want %0d/%0d",
                     tag, fft_size, payload_length_m1, model_fft_size, model_pay_m1);
        end
        fft_config_tready = 1'b0;
        hold_ok = 1'b1;
        repeat (stall) begin
            step();
            if (fft_config_tvalid !== 1'b1 || fft_config_tdata !== word || busy !== 1'b1 ||
                datapath_reset !== 1'b0)
                hold_ok = 1'b0;
        end
        if (stall > 0) begin
            checks++;
            if (!hold_ok) begin
                errors++;
                $display("[TB] FAIL %s cfg_hold got tvalid=%b tdata=0x%04h want 1/0x%04h",
                         tag, fft_config_tvalid, fft_config_tdata, word);
            end
        end
        fft_config_tready = 1'b1;
        step();
        checks++;
        if (fft_config_tvalid !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 ||
            gate_input !== 1'b0 || datapath_reset !== 1'b0 || fft_aresetn !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s run_entry got tvalid=%b busy=%b ready=%b gate=%b want 0/0/1/0",
                     tag, fft_config_tvalid, busy, cfg_ready, gate_input);
        end
    endtask

    task automatic test_reset();
        sync_reset         = 1'b1;
        cfg_valid          = 1'b0;
        cfg_fft_size       = '0;
        cfg_payload_length = '0;
        out_tvalid         = 1'b0;
        out_tready         = 1'b0;
        out_tlast          = 1'b0;
        fft_config_tready  = 1'b1;
        model_defaults();
        step();
        step();
        checks++;
        if (datapath_reset !== 1'b1 || fft_aresetn !== 1'b0 || gate_input !== 1'b1 ||
            busy !== 1'b1 || cfg_ready !== 1'b0 || cfg_err !== 1'b0 || fft_config_tvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got dp=%b an=%b gate=%b busy=%b rdy=%b err=%b tv=%b want 1/0/1/1/0/0/0",
                     datapath_reset, fft_aresetn, gate_input, busy, cfg_ready, cfg_err, fft_config_tvalid);
        end
        checks++;
        if (fft_size !== 12'd8 || payload_length_m1 !== 16'd15) begin
            errors++;
            $display("[TB] FAIL reset_cfg got %0d/%0d want 8/15", fft_size, payload_length_m1);
        end
        sync_reset = 1'b0;
        expect_reset_and_config("power_up", 0);
    endtask

    task automatic test_invalid();
        int  sizes [6] = '{100, 512, 0, 4, 2049, 16};
        int  pays  [6] = '{5, 0, 10, 3, 7, 0};
        int  size, pay;
        bit  idle_ok;
        for (int i = 0; i < 12; i++) begin
            if (i < 6) begin
                size = sizes[i];
                pay  = pays[i];
            end else begin
                size = int'($urandom_range(4095, 0));
                pay  = int'($urandom_range(65535, 0));
                if (model_valid(size, pay)) pay = 0;
            end
            cfg_valid          = 1'b1;
            cfg_fft_size       = 12'(size);
            cfg_payload_length = 16'(pay);
            step();
            cfg_valid          = 1'b0;
            cfg_fft_size       = 12'($urandom);
            cfg_payload_length = 16'($urandom);
            checks++;
            if (cfg_err !== 1'b1 || cfg_ready !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL invalid_%0d_%0d got err=%b ready=%b busy=%b want 1/1/0",
                         size, pay, cfg_err, cfg_ready, busy);
            end
            step();
            checks++;
            if (cfg_err !== 1'b0 || fft_size !== 12'(model_fft_size) ||
                payload_length_m1 !== 16'(model_pay_m1)) begin
                errors++;
                $display("[TB] FAIL invalid_after got err=%b size=%0d pm1=%0d want 0/%0d/%0d",
                         cfg_err, fft_size, payload_length_m1, model_fft_size, model_pay_m1);
            end
        end
        idle_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            out_tvalid = 1'($urandom);
            out_tready = 1'($urandom);
            out_tlast  = 1'($urandom);
            step();
            if (busy !== 1'b0 || cfg_err !== 1'b0 || datapath_reset !== 1'b0) idle_ok = 1'b0;
        end
        out_tvalid = 1'b0;
        out_tready = 1'b0;
        out_tlast  = 1'b0;
        checks++;
        if (!idle_ok) begin
            errors++;
            $display("[TB] FAIL run_ignores_output got busy=%b dp=%b want 0/0", busy, datapath_reset);
        end
    endtask

    task automatic test_valid_reconfig(input int size, input int pay, input int drain_len,
                                       input bit hs_tlast, input int stall);
        bit drain_ok;
        bit tv, tr, tl;
        checks++;
        if (gate_input !== 1'b0 || cfg_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL valid_pre got gate=%b ready=%b want 0/1", gate_input, cfg_ready);
        end
        cfg_valid          = 1'b1;
        cfg_fft_size       = 12'(size);
        cfg_payload_length = 16'(pay);
        if (hs_tlast) begin
            out_tvalid = 1'b1;
            out_tready = 1'b1;
            out_tlast  = 1'b1;
        end
        step();
        cfg_valid  = 1'b0;
        out_tvalid = 1'b0;
        out_tready = 1'b0;
        out_tlast  = 1'b0;
        checks++;
        if (gate_input !== 1'b1 || busy !== 1'b1 || cfg_ready !== 1'b0 || cfg_err !== 1'b0 ||
            datapath_reset !== 1'b0 || fft_size !== 12'(model_fft_size)) begin
            errors++;
            $display("[TB] FAIL drain_entry_%0d got gate=%b busy=%b ready=%b err=%b dp=%b size=%0d want 1/1/0/0/0/%0d",
                     size, gate_input, busy, cfg_ready, cfg_err, datapath_reset, fft_size, model_fft_size);
        end
        drain_ok = 1'b1;
        for (int i = 0; i < drain_len; i++) begin
            tv = 1'($urandom);
            tr = 1'($urandom);
            tl = 1'($urandom);
            if (tv && tr && tl) tl = 1'b0;
            out_tvalid         = tv;
            out_tready         = tr;
            out_tlast          = tl;
            cfg_valid          = 1'($urandom);
            cfg_fft_size       = 12'($urandom);
            cfg_payload_length = 16'($urandom);
            step();
            if (datapath_reset !== 1'b0 || gate_input !== 1'b1 || cfg_err !== 1'b0) drain_ok = 1'b0;
        end
        if (drain_len > 0) begin
            checks++;
            if (!drain_ok) begin
                errors++;
                $display("[TB] FAIL drain_hold_%0d got dp=%b gate=%b err=%b want 0/1/0",
                         size, datapath_reset, gate_input, cfg_err);
            end
        end
        cfg_valid  = 1'b0;
        out_tvalid = 1'b1;
        out_tready = 1'b1;
        out_tlast  = 1'b1;
        step();
        out_tvalid     = 1'b0;
        out_tready     = 1'b0;
        out_tlast      = 1'b0;
        model_fft_size = size;
        model_pay_m1   = pay - 1;
        checks++;
        if (datapath_reset !== 1'b1 || fft_size !== 12'(model_fft_size) ||
            payload_length_m1 !== 16'(model_pay_m1)) begin
            errors++;
            $display("[TB] FAIL drain_exit_%0d got dp=%b size=%0d pm1=%0d want 1/%0d/%0d",
                     size, datapath_reset, fft_size, payload_length_m1, model_fft_size, model_pay_m1);
        end
        expect_reset_and_config("valid_reconfig", stall);
    endtask

    task automatic test_config_backpressure();
        test_valid_reconfig(8 << $urandom_range(8, 0), int'($urandom_range(65535, 1)), 3, 1'b0, 50);
    endtask

    task automatic test_drain_timeout();
        int n;
        int gap;
        cfg_valid          = 1'b1;
        cfg_fft_size       = 12'd2048;
        cfg_payload_length = 16'd128;
        step();
        cfg_valid = 1'b0;
        n = 0;
        while (datapath_reset !== 1'b1 && n < DRAIN_TIMEOUT + 100) begin
            out_tvalid = 1'b0;
            out_tready = 1'($urandom);
            out_tlast  = 1'($urandom);
            step();
            n++;
        end
        out_tready = 1'b0;
        out_tlast  = 1'b0;
        checks++;
        if (n !== DRAIN_TIMEOUT) begin
            errors++;
            $display("[TB] FAIL drain_timeout got %0d cycles want %0d", n, DRAIN_TIMEOUT);
        end
        model_fft_size = 2048;
        model_pay_m1   = 127;
        checks++;
        if (fft_size !== 12'd2048 || payload_length_m1 !== 16'd127) begin
            errors++;
            $display("[TB] FAIL timeout_cfg got %0d/%0d want 2048/127", fft_size, payload_length_m1);
        end
        expect_reset_and_config("timeout", 0);

        gap = int'($urandom_range(4000, 100));
        cfg_valid          = 1'b1;
        cfg_fft_size       = 12'd64;
        cfg_payload_length = 16'd9;
        step();
        cfg_valid = 1'b0;
        n = 0;
        while (datapath_reset !== 1'b1 && n < gap + DRAIN_TIMEOUT + 100) begin
            out_tvalid = (n == gap);
            out_tready = 1'b1;
            out_tlast  = 1'b0;
            step();
            n++;
        end
        out_tvalid = 1'b0;
        out_tready = 1'b0;
        checks++;
        if (n !== gap + 1 + DRAIN_TIMEOUT) begin
            errors++;
            $display("[TB] FAIL timeout_restart got %0d cycles want %0d", n, gap + 1 + DRAIN_TIMEOUT);
        end
        model_fft_size = 64;
        model_pay_m1   = 8;
        expect_reset_and_config("timeout_restart", int'($urandom_range(5, 0)));
    endtask

    task automatic test_reset_mid_drain();
        cfg_valid          = 1'b1;
        cfg_fft_size       = 12'd1024;
        cfg_payload_length = 16'($urandom_range(65535, 1));
        step();
        cfg_valid = 1'b0;
        repeat (5) step();
        #2;
        sync_reset = 1'b1;
        #1;
        model_defaults();
        checks++;
        if (datapath_reset !== 1'b1 || fft_size !== 12'd8 || payload_length_m1 !== 16'd15 ||
            gate_input !== 1'b1 || cfg_ready !== 1'b0 || fft_config_tvalid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_drain_reset got dp=%b size=%0d pm1=%0d gate=%b rdy=%b want 1/8/15/1/0",
                     datapath_reset, fft_size, payload_length_m1, gate_input, cfg_ready);
        end
        step();
        step();
        sync_reset = 1'b0;
        expect_reset_and_config("mid_drain", 0);
        repeat (3) step();
        checks++;
        if (fft_size !== 12'd8 || payload_length_m1 !== 16'd15 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL pending_discarded got %0d/%0d busy=%b want 8/15/0",
                     fft_size, payload_length_m1, busy);
        end
    endtask

    initial begin
        test_reset();
        test_invalid();
        test_valid_reconfig(256, 64, 19, 1'b0, 0);
        for (int it = 0; it < 5; it++) begin
            if (it == 0)
                test_valid_reconfig(8, 1, int'($urandom_range(25, 0)), 1'b1, int'($urandom_range(4, 0)));
            else if (it == 1)
                test_valid_reconfig(2048, 65535, int'($urandom_range(25, 0)), 1'b0, int'($urandom_range(4, 0)));
            else
                test_valid_reconfig(8 << $urandom_range(8, 0), int'($urandom_range(65535, 1)),
                                    int'($urandom_range(25, 0)), 1'($urandom), int'($urandom_range(4, 0)));
        end
        test_config_backpressure();
        test_drain_timeout();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
